par2ser_bit_feeder: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the "1101" sequence detector and drives its serial data input.
- Accepts DATA_W-bit words over a valid/ready handshake.
- Buffers one word in a holding register.
- Shifts words out one bit per enabled cycle, with no bubble between consecutive words.
- Drives 0 on the serial line when idle, so the detector sees no spurious pattern.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/par2ser_hold_buf.sv | 48 ++++
 rtl/par2ser_bit_feeder.sv | 101 ++++++++++
 tb/tb_par2ser_bit_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the parallel-to-serial feeder and the "1101" detector it drives.
package seq_det_pkg;

   localparam int DEFAULT_DATA_W = 8;

   localparam logic [0:0] S_FEED_IDLE  = 1'b0;
   localparam logic [0:0] S_FEED_SHIFT = 1'b1;

   localparam logic [3:0] PATTERN_1101 = 4'b1101;

endpackage

// File: rtl/par2ser_hold_buf.sv
// One-entry word buffer: accepts over valid/ready and releases the word on a drain strobe.
module par2ser_hold_buf
   import seq_det_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              drain,
   output logic              s_ready,
   output logic [DATA_W-1:0] hold,
   output logic              hold_full
);

   logic              full_q, full_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              accept;

   // Ready comes only from the flag, so a drain never reopens the window in the same cycle.
   assign s_ready   = ~full_q & ~rst;
   assign accept    = s_valid & s_ready;
   assign hold      = hold_q;
   assign hold_full = full_q;

   always_comb begin
      full_d = full_q;
      hold_d = hold_q;
      if (accept) begin
         full_d = 1'b1;
         hold_d = s_data;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         hold_q <= '0;
      end else begin
         full_q <= full_d;
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/par2ser_bit_feeder.sv
// Serialises buffered words onto a single bit line with zero-gap streaming between words.
module par2ser_bit_feeder
   import seq_det_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              bit_en,
   output logic              dout,
   output logic              dout_valid,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d, shreg_shifted;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hold;
   logic              hold_full;
   logic              drain;
   logic              out_bit;

   par2ser_hold_buf #(.DATA_W(DATA_W)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .drain     (drain),
      .s_ready   (s_ready),
      .hold      (hold),
      .hold_full (hold_full)
   );

   assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], 1'b0}
                                           : {1'b0, shreg_q[DATA_W-1:1]};
   assign out_bit       = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];

   assign dout       = (state_q == S_FEED_SHIFT) & out_bit;
   assign dout_valid = (state_q == S_FEED_SHIFT) & bit_en;
   assign busy       = (state_q == S_FEED_SHIFT) | hold_full;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      drain   = 1'b0;
      case (state_q)
         S_FEED_IDLE: begin
            if (hold_full) begin
               shreg_d = hold;
               cnt_d   = CNT_FULL;
               drain   = 1'b1;
               state_d = S_FEED_SHIFT;
            end
         end
         S_FEED_SHIFT: begin
            if (bit_en) begin
               if (cnt_q > CNT_ONE) begin
                  shreg_d = shreg_shifted;
                  cnt_d   = cnt_q - CNT_ONE;
               end else if (hold_full) begin
                  // Last bit consumed with a word waiting: reload without a bubble.
                  shreg_d = hold;
                  cnt_d   = CNT_FULL;
                  drain   = 1'b1;
               end else begin
                  shreg_d = shreg_shifted;
                  cnt_d   = '0;
                  state_d = S_FEED_IDLE;
               end
            end
         end
         default: begin
            state_d = S_FEED_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FEED_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_par2ser_bit_feeder.sv
// Bench for par2ser_bit_feeder: directed streams plus randomized traffic against a bit-queue model.
module tb_par2ser_bit_feeder;
   import seq_det_pkg::*;

   localparam int AW = 8;
   localparam int BW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          a_valid, a_ready, a_en, a_dout, a_dv, a_busy;
   logic [AW-1:0] a_data;
   logic          b_valid, b_ready, b_en, b_dout, b_dv, b_busy;
   logic [BW-1:0] b_data;

   par2ser_bit_feeder #(.DATA_W(AW), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
      .bit_en(a_en), .dout(a_dout), .dout_valid(a_dv), .busy(a_busy)
   );

   par2ser_bit_feeder #(.DATA_W(BW), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
      .bit_en(b_en), .dout(b_dout), .dout_valid(b_dv), .busy(b_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model of dut_a: bits still owed to the line (front = on dout now) and the held word.
   bit            mq[$];
   bit            m_held;
   logic [AW-1:0] m_hword;
   bit            m_acc;
   logic [15:0]   a_log;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void m_load(input logic [AW-1:0] w);
      mq.delete();
      for (int i = AW - 1; i >= 0; i--) mq.push_back(w[i]);
   endfunction

   function automatic void m_reset();
      mq.delete();
      m_held = 1'b0;
   endfunction

   // Inputs are driven after the falling edge; outputs are checked 1 time unit later.
   task automatic a_cycle();
      logic [AW-1:0] w;
      bit            exp_bit;
      #1;
      exp_bit = (mq.size() > 0) ? mq[0] : 1'b0;
      chk("a_dout",       32'(a_dout),  32'(exp_bit));
      chk("a_dout_valid", 32'(a_dv),    32'((mq.size() > 0) && a_en));
      chk("a_busy",       32'(a_busy),  32'((mq.size() > 0) || m_held));
      chk("a_s_ready",    32'(a_ready), 32'(!m_held));
      if (a_dv) a_log = {a_log[14:0], a_dout};
      @(posedge clk);
      m_acc = a_valid && !m_held;
      w     = a_data;
      if (mq.size() == 0) begin
         if (m_held) begin
            m_load(m_hword);
            m_held = 1'b0;
         end
      end else if (a_en) begin
         void'(mq.pop_front());
         if (mq.size() == 0 && m_held) begin
            m_load(m_hword);
            m_held = 1'b0;
         end
      end
      if (m_acc) begin
         m_held  = 1'b1;
         m_hword = w;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] b_log;
      logic [3:0] en_pat;
      int         n_acc;
      a_valid = 0; a_data = '0; a_en = 1;
      b_valid = 0; b_data = '0; b_en = 1;
      m_reset();
      a_log = '0;

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_a_s_ready", 32'(a_ready), 32'd0);
      chk("rst_a_dout",    32'(a_dout),  32'd0);
      chk("rst_a_busy",    32'(a_busy),  32'd0);
      chk("rst_a_dv",      32'(a_dv),    32'd0);
      chk("rst_b_s_ready", 32'(b_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      a_cycle();

      // LSB-first 4-bit word 4'hB emits 1,1,0,1 one cycle after accept
      b_valid = 1; b_data = 4'hB;
      @(negedge clk);
      b_valid = 0; b_data = 4'h0;
      @(negedge clk);
      b_log = '0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("b_dout_valid", 32'(b_dv), 32'd1);
         b_log = {b_log[2:0], b_dout};
         @(negedge clk);
      end
      chk("b_pattern", 32'(b_log), 32'(PATTERN_1101));
      #1;
      chk("b_idle_dout", 32'(b_dout), 32'd0);
      chk("b_idle_busy", 32'(b_busy), 32'd0);
      @(negedge clk);

      // Back-to-back 8'hDD, 8'hB4 with s_valid held
      a_log = '0; n_acc = 0;
      a_valid = 1; a_data = 8'hDD;
      for (int c = 0; c < 24; c++) begin
         a_cycle();
         if (m_acc) begin
            n_acc++;
            if (n_acc == 1) a_data = 8'hB4;
            else a_valid = 0;
         end
      end
      chk("a_stream_ddb4", 32'(a_log), 32'h0000DDB4);
      chk("a_accepts",     32'(n_acc), 32'd2);

      // Enable pattern 1,0,0,1 repeating over one word
      a_log = '0; en_pat = 4'b1001;
      a_valid = 1; a_data = 8'h0D;
      a_cycle();
      a_valid = 0;
      for (int c = 0; c < 40; c++) begin
         a_en = en_pat[3 - (c % 4)];
         a_cycle();
      end
      a_en = 1;
      a_cycle();
      chk("a_stream_en", 32'(a_log[7:0]), 32'h0D);

      // Reset mid-word with a second word pending
      a_valid = 1; a_data = 8'hDD;
      a_cycle();
      a_data = 8'h55;
      a_cycle();
      a_cycle();
      a_valid = 0;
      a_cycle();
      #2 rst = 1'b1;
      #1;
      chk("midrst_dout",    32'(a_dout),  32'd0);
      chk("midrst_busy",    32'(a_busy),  32'd0);
      chk("midrst_s_ready", 32'(a_ready), 32'd0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) a_cycle();

      // Randomized traffic with backpressure and bit_en gaps
      for (int c = 0; c < 1500; c++) begin
         a_valid = ($urandom_range(0, 2) != 0);
         a_data  = AW'($urandom);
         a_en    = ($urandom_range(0, 3) != 0);
         a_cycle();
      end
      a_valid = 0; a_en = 1;
      for (int c = 0; c < 20; c++) a_cycle();
      chk("final_idle_busy", 32'(a_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
